// File: rtl/isqrt8_shared_alu.sv
// Multi-cycle 8-bit integer square root that borrows the CPU's combinational ALU for every step.
// Optional remainder output rem_bo is enabled by defining ISQRT_REM_EN.
module isqrt8_shared_alu #(
  parameter logic [2:0] OP_ADD  = 3'b000,
  parameter logic [2:0] OP_OR   = 3'b001,
  parameter logic [2:0] OP_SRL  = 3'b010,
  parameter logic [2:0] OP_SLTU = 3'b011,
  parameter logic [2:0] OP_SUB  = 3'b100
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] x_bi,
  input  logic [7:0] partRes,
  output logic [7:0] partA,
  output logic [7:0] partB,
  output logic [2:0] oper,
  output logic       ready_o,
  output logic [3:0] y_bo
`ifdef ISQRT_REM_EN
  ,
  output logic [7:0] rem_bo
`endif
);

  localparam int unsigned W  = 8;
  localparam int unsigned YW = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OR,
    S_SHR,
    S_CMP,
    S_SUB,
    S_SET,
    S_NEXT
  } state_t;

  state_t         state, state_d;
  logic [W-1:0]   x_q, x_d;
  logic [W-1:0]   y_q, y_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   m_q, m_d;
  logic [YW-1:0]  y_res_d;
  logic [W-1:0]   rem_d;
  logic [W-1:0]   a_req, b_req;
  logic [2:0]     op_req;

  // Next-state and datapath updates; partRes answers the request issued for the current state.
  always_comb begin
    state_d = state;
    x_d     = x_q;
    y_d     = y_q;
    b_d     = b_q;
    m_d     = m_q;
    y_res_d = y_bo;
    rem_d   = x_q;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          x_d     = x_bi;
          y_d     = '0;
          m_d     = W'(8'h40);
          state_d = S_OR;
        end
      end
      S_OR: begin
        b_d     = partRes;
        state_d = S_SHR;
      end
      S_SHR: begin
        y_d     = partRes;
        state_d = S_CMP;
      end
      S_CMP: begin
        state_d = partRes[0] ? S_NEXT : S_SUB;
      end
      S_SUB: begin
        x_d     = partRes;
        state_d = S_SET;
      end
      S_SET: begin
        y_d     = partRes;
        state_d = S_NEXT;
      end
      S_NEXT: begin
        m_d = partRes;
        if (partRes == '0) begin
          y_res_d = y_q[YW-1:0];
          state_d = S_IDLE;
        end else begin
          state_d = S_OR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ALU request for the upcoming state, built from next-cycle register values so it can be registered.
  always_comb begin
    a_req  = '0;
    b_req  = '0;
    op_req = OP_ADD;
    case (state_d)
      S_OR: begin
        a_req  = y_d;
        b_req  = m_d;
        op_req = OP_OR;
      end
      S_SHR: begin
        a_req  = y_d;
        b_req  = W'(8'd1);
        op_req = OP_SRL;
      end
      S_CMP: begin
        a_req  = x_d;
        b_req  = b_d;
        op_req = OP_SLTU;
      end
      S_SUB: begin
        a_req  = x_d;
        b_req  = b_d;
        op_req = OP_SUB;
      end
      S_SET: begin
        a_req  = y_d;
        b_req  = m_d;
        op_req = OP_OR;
      end
      S_NEXT: begin
        a_req  = m_d;
        b_req  = W'(8'd2);
        op_req = OP_SRL;
      end
      default: begin
        a_req  = '0;
        b_req  = '0;
        op_req = OP_ADD;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      partA   <= '0;
      partB   <= '0;
      oper    <= OP_ADD;
      ready_o <= 1'b1;
      y_bo    <= '0;
`ifdef ISQRT_REM_EN
      rem_bo  <= '0;
`endif
    end else begin
      state   <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      b_q     <= b_d;
      m_q     <= m_d;
      partA   <= a_req;
      partB   <= b_req;
      oper    <= op_req;
      ready_o <= (state_d == S_IDLE);
      y_bo    <= y_res_d;
`ifdef ISQRT_REM_EN
      // Remainder is captured on the same edge as the root.
      if (state == S_NEXT && partRes == '0) rem_bo <= rem_d;
`endif
    end
  end

endmodule

// File: tb/tb_isqrt8_shared_alu.sv
// Self-checking bench for isqrt8_shared_alu: combinational ALU model, vector table, sweep, random runs.
module tb_isqrt8_shared_alu;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_SRL  = 3'b010;
  localparam logic [2:0] OP_SLTU = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic [7:0] x_bi;
  logic [7:0] partRes;
  logic [7:0] partA;
  logic [7:0] partB;
  logic [2:0] oper;
  logic       ready_o;
  logic [3:0] y_bo;
`ifdef ISQRT_REM_EN
  logic [7:0] rem_bo;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  isqrt8_shared_alu dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .x_bi    (x_bi),
    .partRes (partRes),
    .partA   (partA),
    .partB   (partB),
    .oper    (oper),
    .ready_o (ready_o),
    .y_bo    (y_bo)
`ifdef ISQRT_REM_EN
    ,
    .rem_bo  (rem_bo)
`endif
  );

  always #5 clk_i = ~clk_i;

  // The CPU's ALU as seen by the unit.
  always_comb begin
    case (oper)
      OP_ADD:  partRes = partA + partB;
      OP_OR:   partRes = partA | partB;
      OP_SRL:  partRes = partA >> partB[4:0];
      OP_SLTU: partRes = {7'd0, (partA < partB)};
      OP_SUB:  partRes = partA - partB;
      default: partRes = 8'd0;
    endcase
  end

  function automatic int ref_root(input int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Start one operation; optionally pulse a spurious start with a random x at busy cycle glitch.
  task automatic run_op(input logic [7:0] xv, input int glitch, output int busy);
    @(negedge clk_i);
    start_i = 1'b1;
    x_bi    = xv;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    x_bi    = 8'($urandom);
    busy    = 0;
    while (!ready_o && busy < 100) begin
      if (busy == glitch) begin
        @(negedge clk_i);
        start_i = 1'b1;
        x_bi    = 8'($urandom);
        @(posedge clk_i); #1;
        start_i = 1'b0;
      end else begin
        @(posedge clk_i); #1;
      end
      busy++;
    end
    if (busy >= 100) check("timeout", busy, 0);
  endtask

  task automatic run_and_check(input logic [7:0] xv, input int glitch, input int hold);
    int busy;
    int r;
    logic [3:0] held;
    r = ref_root(int'(xv));
    run_op(xv, glitch, busy);
    check($sformatf("root x=%0d", xv), int'(y_bo), r);
    check($sformatf("busy x=%0d", xv), busy, 16 + 2 * $countones(4'(r)));
`ifdef ISQRT_REM_EN
    check($sformatf("rem x=%0d", xv), int'(rem_bo), int'(xv) - r * r);
`endif
    held = 4'(r);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk_i); #1;
      check("ready hold", int'(ready_o), 1);
      check("y hold", int'(y_bo), int'(held));
    end
  endtask

  typedef struct {
    logic [7:0] x;
    int         busy;
    int         y;
    int         rem;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int busy;
    tbl[0] = '{x: 8'd0,   busy: 16, y: 0,  rem: 0};
    tbl[1] = '{x: 8'd16,  busy: 18, y: 4,  rem: 0};
    tbl[2] = '{x: 8'd125, busy: 22, y: 11, rem: 4};
    tbl[3] = '{x: 8'd255, busy: 24, y: 15, rem: 30};

    rst_i   = 1'b1;
    start_i = 1'b0;
    x_bi    = 8'd0;
    repeat (2) @(posedge clk_i);
    #1;
    check("reset ready", int'(ready_o), 1);
    check("reset y", int'(y_bo), 0);
    check("reset oper", int'(oper), int'(OP_ADD));
    check("reset partA", int'(partA), 0);
    check("reset partB", int'(partB), 0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // First request after accept is y|m with m=0x40.
    @(negedge clk_i);
    start_i = 1'b1;
    x_bi    = 8'd77;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    check("accept ready", int'(ready_o), 0);
    check("accept oper", int'(oper), int'(OP_OR));
    check("accept partA", int'(partA), 0);
    check("accept partB", int'(partB), 8'h40);
    busy = 0;
    while (!ready_o && busy < 100) begin
      @(posedge clk_i); #1;
      busy++;
    end
    check("root x=77", int'(y_bo), 8);
    check("idle oper", int'(oper), int'(OP_ADD));

    foreach (tbl[i]) begin
      run_op(tbl[i].x, -1, busy);
      check($sformatf("tbl root x=%0d", tbl[i].x), int'(y_bo), tbl[i].y);
      check($sformatf("tbl busy x=%0d", tbl[i].x), busy, tbl[i].busy);
`ifdef ISQRT_REM_EN
      check($sformatf("tbl rem x=%0d", tbl[i].x), int'(rem_bo), tbl[i].rem);
`endif
    end

    for (int v = 0; v < 256; v++) run_and_check(8'(v), -1, 2);

    // Spurious start while busy must be ignored.
    run_and_check(8'd200, 5, 1);
    run_and_check(8'd3, 1, 1);

    // Reset in the middle of an operation.
    @(negedge clk_i);
    start_i = 1'b1;
    x_bi    = 8'd255;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (7) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    check("midrst ready", int'(ready_o), 1);
    check("midrst y", int'(y_bo), 0);
    check("midrst oper", int'(oper), int'(OP_ADD));
    check("midrst partA", int'(partA), 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    run_and_check(8'd100, -1, 1);

    // Random radicands, idle gaps and spurious starts.
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk_i);
      run_and_check(8'($urandom), int'($urandom_range(0, 14)), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
